// File: rtl/instr_mem_loader.sv
// Byte-serial instruction-memory loader: packs MSB-first bytes into 32-bit words and writes
// them to consecutive word addresses, then pulses done.
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MaxWords = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] OneWord  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_word, w_word_d;
  logic [1:0]        r_byte_cnt, w_byte_cnt_d;
  logic [ADDR_W:0]   r_word_cnt, w_word_cnt_d;
  logic [ADDR_W:0]   r_num_words, w_num_words_d;
  logic              r_err, w_err_d;
  logic              w_len_ok;
  logic [ADDR_W:0]   w_word_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_num_words <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_word      <= w_word_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_word_cnt  <= w_word_cnt_d;
      r_num_words <= w_num_words_d;
      r_err       <= w_err_d;
    end
  end

  assign w_len_ok       = (num_words != '0) && (num_words <= MaxWords);
  assign w_word_cnt_inc = r_word_cnt + OneWord;

  always_comb begin
    w_state_d     = r_state;
    w_word_d      = r_word;
    w_byte_cnt_d  = r_byte_cnt;
    w_word_cnt_d  = r_word_cnt;
    w_num_words_d = r_num_words;
    w_err_d       = r_err;
    byte_ready    = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    done          = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (w_len_ok) begin
            w_num_words_d = num_words;
            w_err_d       = 1'b0;
            w_word_cnt_d  = '0;
            w_byte_cnt_d  = '0;
            w_word_d      = '0;
            w_state_d     = StCollect;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StCollect: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          w_word_d     = {r_word[23:0], byte_data};
          w_byte_cnt_d = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_we       = 1'b1;
        mem_addr     = 32'(r_word_cnt[ADDR_W-1:0]);
        mem_wdata    = r_word;
        w_word_cnt_d = w_word_cnt_inc;
        // Full-width compare so a MAX_WORDS = 2^ADDR_W load terminates instead of wrapping.
        w_state_d    = (w_word_cnt_inc == r_num_words) ? StDone : StCollect;
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign busy = (r_state != StIdle);
  assign err  = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised and directed bench for instr_mem_loader; a transaction-level model predicts every
// output each cycle and a write log pins the directed load results.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  instr_mem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is a list of words; each word is 4 accepted bytes followed by a write cycle,
  // the last write followed by one done cycle.
  bit          m_active, m_err, m_cur_we, m_cur_done;
  int          m_total, m_written;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr, m_data;
  bit          nwe, ndone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_err = 0; m_cur_we = 0; m_cur_done = 0;
      m_total = 0; m_written = 0; m_bytes.delete();
      m_addr = 0; m_data = 0;
    end else begin
      nwe = 0;
      ndone = 0;
      if (!m_active) begin
        if (start) begin
          if (num_words >= 1 && num_words <= 256) begin
            m_active = 1; m_total = int'(num_words); m_written = 0; m_err = 0;
            m_bytes.delete();
          end else begin
            m_err = 1;
          end
        end
      end else if (m_cur_we) begin
        m_written++;
        if (m_written == m_total) ndone = 1;
      end else if (m_cur_done) begin
        m_active = 0;
      end else if (byte_valid) begin
        m_bytes.push_back(byte_data);
        if (m_bytes.size() == 4) begin
          nwe = 1;
          m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_addr = 32'(m_written);
          m_bytes.delete();
        end
      end
      m_cur_we = nwe;
      m_cur_done = ndone;
    end
  end

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_active));
    chk("byte_ready", 32'(byte_ready), 32'(m_active && !m_cur_we && !m_cur_done));
    chk("mem_we", 32'(mem_we), 32'(m_cur_we));
    chk("done", 32'(done), 32'(m_cur_done));
    chk("err", 32'(err), 32'(m_err));
    chk("no_x", 32'($isunknown({mem_addr, mem_wdata})), 32'(0));
    if (m_cur_we) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_data);
    end
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  logic [31:0] load_words[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int guard;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    forever begin
      @(negedge clk);
      ok = byte_ready;
      tick();
      if (ok) break;
      guard++;
      if (guard > 20) begin
        chk("byte_accept_timeout", 32'(1), 32'(0));
        break;
      end
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic begin_load(input int n, input bit hold);
    num_words = 9'(n);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  // mode: 0 back-to-back, 1 three idle cycles per byte, 2 random gaps, 3 incrementing data
  task automatic run_load(input int n, input int mode, input bit hold);
    logic [31:0] w;
    int gap;
    bit found;
    begin_load(n, hold);
    for (int i = 0; i < n; i++) begin
      if (mode == 3) w = 32'(i);
      else if (i < load_words.size()) w = load_words[i];
      else w = $urandom;
      for (int k = 3; k >= 0; k--) begin
        gap = (mode == 1) ? 3 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
        send_byte(w[8*k +: 8], gap);
      end
    end
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        start = 1'b0;
        break;
      end
    end
    chk("done_seen", 32'(found), 32'(1));
    tick();
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'(0));
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    #8;
    chk("rst_outputs", {byte_ready, mem_we, busy, done, err}, 32'(0));
    chk("rst_addr_data", mem_addr | mem_wdata, 32'(0));
    #8 rst_n = 1'b1;
    tick();

    // Directed two-word load, back-to-back then with idle gaps.
    for (int pass = 0; pass < 2; pass++) begin
      log_addr.delete(); log_data.delete();
      load_words = '{32'h2008_0005, 32'h8C09_0004};
      run_load(2, pass, 0);
      chk("two_word_count", 32'(log_addr.size()), 32'(2));
      if (log_addr.size() == 2) begin
        chk("w0_addr", log_addr[0], 32'h0);
        chk("w0_data", log_data[0], 32'h2008_0005);
        chk("w1_addr", log_addr[1], 32'h1);
        chk("w1_data", log_data[1], 32'h8C09_0004);
      end
    end
    load_words.delete();

    // Illegal lengths set err and start nothing; a legal start clears it.
    log_addr.delete(); log_data.delete();
    begin_load(0, 0);
    @(negedge clk);
    chk("err_len0", 32'(err), 32'(1));
    chk("busy_len0", 32'(busy), 32'(0));
    #1;
    begin_load(300, 0);
    @(negedge clk);
    chk("err_len300", 32'(err), 32'(1));
    #1;
    chk("no_write_illegal", 32'(log_addr.size()), 32'(0));
    begin_load(257, 0);
    @(negedge clk);
    chk("err_len257", 32'(err), 32'(1));
    #1;
    run_load(1, 2, 0);
    chk("err_cleared", 32'(err), 32'(0));
    chk("one_write", 32'(log_addr.size()), 32'(1));
    if (log_addr.size() == 1) chk("one_write_addr", log_addr[0], 32'h0);

    // Reset mid-load discards the partial word.
    log_addr.delete(); log_data.delete();
    begin_load(3, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {byte_ready, mem_we, busy, done, err}, 32'(0));
    chk("midrst_addr_data", mem_addr | mem_wdata, 32'(0));
    #7 rst_n = 1'b1;
    tick();
    chk("midrst_no_write", 32'(log_addr.size()), 32'(0));
    run_load(1, 0, 0);
    chk("after_rst_count", 32'(log_addr.size()), 32'(1));
    if (log_addr.size() == 1) chk("after_rst_addr", log_addr[0], 32'h0);

    // Full-depth load with start held high.
    log_addr.delete(); log_data.delete();
    run_load(256, 3, 1);
    chk("full_count", 32'(log_addr.size()), 32'(256));
    if (log_addr.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        if (log_addr[i] !== 32'(i) || log_data[i] !== 32'(i))
          chk("full_seq", log_addr[i], 32'(i));
      end
      chk("full_last_addr", log_addr[255], 32'd255);
    end
    chk("full_no_restart", 32'(busy), 32'(0));

    // Random loads with random data and gaps, occasionally preceded by an illegal start.
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        begin_load((($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(257, 511))), 0);
      end
      run_load(int'($urandom_range(1, 6)), 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
